// File: rtl/fifo_queue_arbiter_pkg.sv
// fifo_queue_arbiter_pkg
//   Shared definitions for the fifo_queue write-port arbiter.
//   - arb_state_t : arbiter state encoding (IDLE / ISSUE / RELEASE)
//   - FQA_SLICE   : extracts producer idx's entry from a packed request bus
`ifndef FIFO_QUEUE_ARBITER_PKG_SV
`define FIFO_QUEUE_ARBITER_PKG_SV

// Producer idx occupies bits [idx*w +: w] of a packed request bus.
`define FQA_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package fifo_queue_arbiter_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_ISSUE   = 2'd1,
    STATE_RELEASE = 2'd2
  } arb_state_t;

endpackage

`endif

// File: rtl/round_robin_priority_encoder.sv
// round_robin_priority_encoder
//   Combinational round-robin pick: first set bit of valid_in searching
//   upward from pointer_in, wrapping at NUM_REQUESTER-1 (works for
//   non-power-of-two counts).
//   Ports:
//     valid_in          per-producer valid
//     pointer_in        highest-priority index this round (< NUM_REQUESTER)
//     grant_index_out   winning index (0 when nothing valid)
//     grant_onehot_out  winning index as one-hot (0 when nothing valid)
//     any_valid_out     at least one valid bit set
module round_robin_priority_encoder #(
  parameter int NUM_REQUESTER               = 4,
  parameter int NUM_REQUESTER_WIDTH_IN_BITS = 2
) (
  input  logic [NUM_REQUESTER-1:0]               valid_in,
  input  logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0] pointer_in,
  output logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0] grant_index_out,
  output logic [NUM_REQUESTER-1:0]               grant_onehot_out,
  output logic                                   any_valid_out
);

  localparam int IW = NUM_REQUESTER_WIDTH_IN_BITS;
  // One extra bit so pointer+offset (at most 2*N-2) never overflows before wrap.
  localparam int PW = IW + 1;

  logic [PW-1:0] idx;

  always_comb begin
    idx              = '0;
    grant_index_out  = '0;
    grant_onehot_out = '0;
    any_valid_out    = 1'b0;
    for (int off = 0; off < NUM_REQUESTER; off++) begin
      idx = {1'b0, pointer_in} + PW'(off);
      if (idx >= PW'(NUM_REQUESTER)) idx = idx - PW'(NUM_REQUESTER);
      // Only the first hit in search order wins.
      if (!any_valid_out && valid_in[idx[IW-1:0]]) begin
        any_valid_out                     = 1'b1;
        grant_index_out                   = idx[IW-1:0];
        grant_onehot_out[idx[IW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_queue_arbiter.sv
// fifo_queue_arbiter
//   Round-robin arbiter sharing one fifo_queue write port between
//   NUM_REQUESTER producers. IDLE picks a producer, ISSUE holds the entry
//   until the queue acks, RELEASE pulses the producer ack for one cycle.
//   All outputs are registered.
//   Ports:
//     clk_in, reset_in           clock, asynchronous active-high reset
//     request_packed_in          producer entries, producer i at [i*W +: W]
//     request_valid_packed_in    per-producer valid
//     issue_ack_packed_out       one-hot, one-cycle ack to granted producer
//     request_to_fifo_out        entry to queue request_in
//     request_valid_to_fifo_out  queue request_valid_in
//     issue_ack_from_fifo_in     queue issue_ack_out
//     is_full_from_fifo_in       queue is_full_out (sampled in IDLE only)
//     grant_index_out            current / last granted index
module fifo_queue_arbiter
  import fifo_queue_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTER               = 4,
  parameter int NUM_REQUESTER_WIDTH_IN_BITS = 2,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS  = 32
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUESTER-1:0]                            request_valid_packed_in,
  output logic [NUM_REQUESTER-1:0]                            issue_ack_packed_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_to_fifo_out,
  output logic                                                request_valid_to_fifo_out,
  input  logic                                                issue_ack_from_fifo_in,
  input  logic                                                is_full_from_fifo_in,
  output logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0]              grant_index_out
);

  localparam int N  = NUM_REQUESTER;
  localparam int IW = NUM_REQUESTER_WIDTH_IN_BITS;
  localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;

  arb_state_t           state;
  logic [IW-1:0]        pointer;
  logic [N-1:0]         grant_onehot_q;
  logic [IW-1:0]        next_pointer;

  logic [N-1:0][W-1:0]  req_entries;
  logic [IW-1:0]        enc_index;
  logic [N-1:0]         enc_onehot;
  logic                 enc_any;

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign req_entries[g] = `FQA_SLICE(request_packed_in, g, W);
  end

  round_robin_priority_encoder #(
    .NUM_REQUESTER               (N),
    .NUM_REQUESTER_WIDTH_IN_BITS (IW)
  ) u_rr_enc (
    .valid_in         (request_valid_packed_in),
    .pointer_in       (pointer),
    .grant_index_out  (enc_index),
    .grant_onehot_out (enc_onehot),
    .any_valid_out    (enc_any)
  );

  // Explicit wrap so non-power-of-two counts stay in range.
  assign next_pointer = (grant_index_out == IW'(N - 1)) ? '0 : grant_index_out + 1'b1;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state                     <= STATE_IDLE;
      pointer                   <= '0;
      grant_onehot_q            <= '0;
      issue_ack_packed_out      <= '0;
      request_to_fifo_out       <= '0;
      request_valid_to_fifo_out <= 1'b0;
      grant_index_out           <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (!is_full_from_fifo_in && enc_any) begin
            request_to_fifo_out       <= req_entries[enc_index];
            request_valid_to_fifo_out <= 1'b1;
            grant_index_out           <= enc_index;
            grant_onehot_q            <= enc_onehot;
            state                     <= STATE_ISSUE;
          end
        end
        // Producer valids are not looked at here: the entry is already latched.
        STATE_ISSUE: begin
          if (issue_ack_from_fifo_in) begin
            request_valid_to_fifo_out <= 1'b0;
            issue_ack_packed_out      <= grant_onehot_q;
            pointer                   <= next_pointer;
            state                     <= STATE_RELEASE;
          end
        end
        // One dead cycle lets the acked producer retire its valid before
        // IDLE samples again, so an entry is never issued twice.
        STATE_RELEASE: begin
          issue_ack_packed_out <= '0;
          state                <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_queue_arbiter.sv
module tb_fifo_queue_arbiter;
  localparam int N = 4, IW = 2, W = 32, QDEPTH = 8;

  logic                clk_in = 1'b0;
  logic                reset_in = 1'b1;
  logic [N*W-1:0]      request_packed_in = '0;
  logic [N-1:0]        request_valid_packed_in = '0;
  logic [N-1:0]        issue_ack_packed_out;
  logic [W-1:0]        request_to_fifo_out;
  logic                request_valid_to_fifo_out;
  logic                issue_ack_from_fifo_in = 1'b0;
  logic                is_full_from_fifo_in = 1'b0;
  logic [IW-1:0]       grant_index_out;

  fifo_queue_arbiter #(
    .NUM_REQUESTER(N), .NUM_REQUESTER_WIDTH_IN_BITS(IW), .SINGLE_ENTRY_WIDTH_IN_BITS(W)
  ) dut (
    .clk_in                    (clk_in),
    .reset_in                  (reset_in),
    .request_packed_in         (request_packed_in),
    .request_valid_packed_in   (request_valid_packed_in),
    .issue_ack_packed_out      (issue_ack_packed_out),
    .request_to_fifo_out       (request_to_fifo_out),
    .request_valid_to_fifo_out (request_valid_to_fifo_out),
    .issue_ack_from_fifo_in    (issue_ack_from_fifo_in),
    .is_full_from_fifo_in      (is_full_from_fifo_in),
    .grant_index_out           (grant_index_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int prod; logic [W-1:0] data; } xfer_t;

  logic [W-1:0] pend [N][$];   // per-producer pending entries
  xfer_t        exp_q[$];      // scoreboard: expected transfers in order
  logic [W-1:0] fifo_q[$];     // queue model contents
  logic [W-1:0] cap_q[$];      // entries accepted by the queue, awaiting producer ack

  int checks = 0, errors = 0, acks_seen = 0;
  bit ack_en = 1, drop_en = 0;
  int fixed_delay = -1, pop_budget = -1, wait_cnt = 0, delay = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: round robin over producers with pending work, pointer starts
  // at 0 after reset and moves past each winner.
  function automatic void predict();
    logic [W-1:0] m [N][$];
    int ptr = 0, total = 0;
    xfer_t x;
    for (int i = 0; i < N; i++) begin m[i] = pend[i]; total += m[i].size(); end
    repeat (total) begin
      for (int k = 0; k < N; k++) begin
        int p = (ptr + k) % N;
        if (m[p].size() > 0) begin
          x.prod = p; x.data = m[p].pop_front();
          exp_q.push_back(x);
          ptr = (p + 1) % N;
          break;
        end
      end
    end
  endfunction

  // Producers: present head entry; retire it on ack. Optionally drop valid
  // while its entry is being issued (must not cancel the transfer).
  always @(posedge clk_in) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!reset_in && issue_ack_packed_out[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      if (pend[i].size() > 0 &&
          !(drop_en && request_valid_to_fifo_out && grant_index_out == IW'(i) && $urandom_range(0, 1) == 1)) begin
        request_valid_packed_in[i] = 1'b1;
        request_packed_in[i*W +: W] = pend[i][0];
      end else begin
        request_valid_packed_in[i] = 1'b0;
        request_packed_in[i*W +: W] = $urandom;
      end
    end
  end

  // Queue model: depth QDEPTH, ack after a random/forced delay, random pops.
  always @(posedge clk_in) begin
    #1;
    if (reset_in) begin
      fifo_q.delete();
      issue_ack_from_fifo_in = 1'b0;
      wait_cnt = 0;
    end else begin
      if (issue_ack_from_fifo_in) issue_ack_from_fifo_in = 1'b0;
      else if (request_valid_to_fifo_out) begin
        if (wait_cnt == 0) delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 6));
        if (ack_en && wait_cnt >= delay && fifo_q.size() < QDEPTH) begin
          fifo_q.push_back(request_to_fifo_out);
          cap_q.push_back(request_to_fifo_out);
          issue_ack_from_fifo_in = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end
      if (fifo_q.size() > 0 && (pop_budget > 0 || (pop_budget < 0 && $urandom_range(0, 1) == 1))) begin
        void'(fifo_q.pop_front());
        if (pop_budget > 0) pop_budget--;
      end
    end
    is_full_from_fifo_in = (fifo_q.size() >= QDEPTH);
  end

  // Monitor: compares producer acks against the scoreboard and watches the
  // queue-side handshake rules.
  logic         prev_qack = 0, prev_valid = 0, prev_full = 0;
  logic [W-1:0] prev_entry = '0;
  always @(negedge clk_in) begin
    xfer_t e;
    if (reset_in) begin
      prev_qack = 0; prev_valid = 0; prev_full = 0;
    end else begin
      if (prev_qack || issue_ack_packed_out != '0)
        chk("ack_one_cycle_after_queue_ack", {63'd0, issue_ack_packed_out != '0}, {63'd0, prev_qack});
      if (issue_ack_packed_out != '0) begin
        acks_seen++;
        if (exp_q.size() == 0) chk("unexpected_ack", 64'(issue_ack_packed_out), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("ack_onehot", 64'(issue_ack_packed_out), 64'(1) << e.prod);
          chk("grant_index", 64'(grant_index_out), 64'(e.prod));
          chk("queue_capture_count", 64'(cap_q.size()), 64'd1);
          if (cap_q.size() > 0) chk("queue_entry", 64'(cap_q.pop_front()), 64'(e.data));
        end
      end
      if (prev_valid && request_valid_to_fifo_out)
        chk("entry_stable", 64'(request_to_fifo_out), 64'(prev_entry));
      if (!prev_valid && request_valid_to_fifo_out)
        chk("no_grant_while_full", {63'd0, prev_full}, 64'd0);
      prev_qack  = issue_ack_from_fifo_in;
      prev_valid = request_valid_to_fifo_out;
      prev_full  = is_full_from_fifo_in;
      prev_entry = request_to_fifo_out;
    end
  end

  task automatic enter_reset();
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int i = 0; i < N; i++) pend[i].delete();
    exp_q.delete(); cap_q.delete();
    #1;
    chk("reset_valid_to_fifo", {63'd0, request_valid_to_fifo_out}, 64'd0);
    chk("reset_issue_ack", 64'(issue_ack_packed_out), 64'd0);
    chk("reset_grant_index", 64'(grant_index_out), 64'd0);
    chk("reset_entry", 64'(request_to_fifo_out), 64'd0);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic leave_reset();
    predict();
    @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  task automatic run_until_done(int budget);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) @(negedge clk_in);
    chk("drained_in_budget", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Single producer, all-ones entry.
    enter_reset();
    pend[0].push_back(32'hFFFF_FFFF);
    leave_reset();
    run_until_done(100);

    // All four continuously valid.
    enter_reset();
    for (int i = 0; i < N; i++) begin
      pend[i].push_back(32'hA0 + i); pend[i].push_back(32'hA0 + i);
    end
    leave_reset();
    run_until_done(300);

    // Valids 1010: p1, then p3, then p1 again.
    enter_reset();
    pend[1].push_back(32'h11); pend[1].push_back(32'h12); pend[3].push_back(32'h31);
    leave_reset();
    run_until_done(200);

    // Queue stalled: 12 entries from producer 2, only 8 fit.
    enter_reset();
    pop_budget = 0;
    for (int k = 0; k < 12; k++) pend[2].push_back(32'h2000 + k);
    base = acks_seen;
    leave_reset();
    repeat (150) @(negedge clk_in);
    chk("acks_while_full", 64'(acks_seen - base), 64'd8);
    chk("valid_to_fifo_while_full", {63'd0, request_valid_to_fifo_out}, 64'd0);
    pop_budget = 3;
    repeat (100) @(negedge clk_in);
    chk("acks_after_3_pops", 64'(acks_seen - base), 64'd11);
    pop_budget = -1;
    run_until_done(200);

    // Queue ack withheld 5 cycles, producer drops valid mid-issue.
    enter_reset();
    fixed_delay = 5; drop_en = 1;
    pend[3].push_back(32'hD5D5_0003); pend[0].push_back(32'hD5D5_0000);
    leave_reset();
    run_until_done(100);
    fixed_delay = -1;

    // Randomized rounds.
    for (int r = 0; r < 15; r++) begin
      enter_reset();
      for (int i = 0; i < N; i++) begin
        int len = $urandom_range(0, 4);
        for (int k = 0; k < len; k++) pend[i].push_back($urandom);
      end
      leave_reset();
      run_until_done(400);
    end
    drop_en = 0;

    // Reset while in ISSUE: entry dropped, no producer ack.
    enter_reset();
    ack_en = 0;
    pend[1].push_back(32'hBADD_0001);
    leave_reset();
    exp_q.delete();  // this entry is never expected to complete
    for (int c = 0; c < 20 && !request_valid_to_fifo_out; c++) @(negedge clk_in);
    chk("granted_before_reset", {63'd0, request_valid_to_fifo_out}, 64'd1);
    base = acks_seen;
    enter_reset();
    ack_en = 1;
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (12) @(negedge clk_in);
    chk("no_ack_for_dropped_entry", 64'(acks_seen - base), 64'd0);
    chk("idle_after_reset_valid", {63'd0, request_valid_to_fifo_out}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
